mont_convert: RTL
=================

MONT_CONVERT -- requirements
Module: mont_convert

Interface
REQ-001 SHALL have parameter WIDTH, default 512: operand width in bits; R = 2^WIDTH.
REQ-002 SHALL have port clk_in, input, 1: the only clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_in, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port base_in, input, WIDTH: plain-form base; any value, including values >= modulo_in.
REQ-005 SHALL have port modulo_in, input, WIDTH: modulus N.
REQ-006 SHALL have port valid_in, input, 1: base_in and modulo_in are valid.
REQ-007 SHALL have port ready_in, input, 1: downstream exponentiator accepts the result.
REQ-008 SHALL have port base_mont_out, output, WIDTH: (base * R) mod N.
REQ-009 SHALL have port one_mont_out, output, WIDTH: R mod N, the Montgomery form of 1 for the exponentiator start product.
REQ-010 SHALL have port modulo_out, output, WIDTH: captured N, registered alongside the results.
REQ-011 SHALL have port valid_out, input-to-output handshake flag, output, 1: results valid; held until accepted.
REQ-012 SHALL have port busy_out, output, 1: high from acceptance until the result is consumed.
REQ-013 SHALL have port error_out, output, 1: high with valid_out when N < 2.

Function
REQ-014 SHALL implement states IDLE, SHIFT and DONE only.
REQ-015 In IDLE, valid_in=1 SHALL be accepted on that edge: capture base and N, clear both accumulators, set the bit counter to 2*WIDTH-1, set busy_out=1, and go to SHIFT.
REQ-016 valid_in SHALL be ignored in SHIFT and DONE, and captured operands SHALL NOT change until the next acceptance.
REQ-017 In SHIFT, each cycle SHALL process one bit, MSB first, of the 2*WIDTH-bit streams {base, WIDTH zeros} and {1 at bit position WIDTH, zeros elsewhere}, using acc' = 2*acc + bit, followed by acc' - N if acc' >= N.
REQ-018 Accumulators SHALL be WIDTH+1 bits wide, since acc' < 2N; the compare and subtract SHALL use the full WIDTH+1 bits with no truncation before the compare.
REQ-019 After the counter-0 step, SHALL load base_mont_out, one_mont_out and modulo_out, set valid_out=1, and go to DONE; valid_out SHALL rise exactly 2*WIDTH edges after the accepting edge.
REQ-020 In DONE, outputs SHALL hold stable while ready_in=0; on ready_in=1, SHALL clear valid_out, busy_out and error_out on that edge and return to IDLE.
REQ-021 A new valid_in SHALL NOT be accepted on the same edge as the DONE->IDLE transition; the minimum spacing between acceptances SHALL be 2*WIDTH+2 edges.
REQ-022 If N is 0 or 1 at acceptance, SHALL skip SHIFT, go to DONE on the next edge with both results 0 and error_out=1.
REQ-023 Even N SHALL be computed correctly (the arithmetic is valid), with no error flagged; oddness is the downstream block's concern.

Reset
REQ-024 rst_in low SHALL immediately force IDLE, valid_out=0, busy_out=0, error_out=0, all outputs 0, accumulators 0 and counter 0, including mid-SHIFT or mid-DONE.
REQ-025 After rst_in deasserts, the first valid_in SHALL be accepted normally, with no residue from the aborted operation.

Structure
REQ-026 The default WIDTH constant SHALL live in the shared RSA package; the state enum SHALL stay local to the module.
REQ-027 One combinational sub-module, mod_double_step (acc, bit, N -> acc'), SHALL be instantiated twice, once per accumulator.
REQ-028 SHALL contain no multipliers, to keep the multipliers free for the exponentiator.

Verification (WIDTH=8, R=256)
REQ-029 N=13, base=5, ready_in=1: valid_out at edge 16 after acceptance, with base_mont_out=6, one_mont_out=9, error_out=0.
REQ-030 N=13, base=20 (base >= N): base_mont_out=11, one_mont_out=9.
REQ-031 N=255, base=254, ready_in held 0 for 10 cycles: base_mont_out=254 and one_mont_out=1 held stable; valid_in pulses during the wait are ignored; release of ready_in returns to IDLE.
REQ-032 N=1, base=7: valid_out and error_out on the edge after acceptance; both results 0.
REQ-033 rst_in low at edge 5 of SHIFT: all outputs 0 immediately; after release, N=13 and base=5 yields 6 and 9 with correct latency.
REQ-034 Randomized N >= 2 and base, 200 runs: results match a reference model (base*256)%N and 256%N.

Source files
------------

// File: rtl/mont_convert_pkg.sv
// Shared RSA datapath constants and helpers used by the Montgomery front end.
package mont_convert_pkg;

    localparam int unsigned RSA_WIDTH = 512;

    // Bit-counter width needed to walk a 2*w-bit stream.
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(2 * w);
    endfunction

endpackage

// File: rtl/mont_convert_if.sv
// Operand/result handshake bundle between the Montgomery converter and its neighbours.
import mont_convert_pkg::*;

interface mont_convert_if #(
    parameter int unsigned WIDTH = RSA_WIDTH
);
    logic [WIDTH-1:0] base_in;
    logic [WIDTH-1:0] modulo_in;
    logic             valid_in;
    logic             ready_in;
    logic [WIDTH-1:0] base_mont_out;
    logic [WIDTH-1:0] one_mont_out;
    logic [WIDTH-1:0] modulo_out;
    logic             valid_out;
    logic             busy_out;
    logic             error_out;

    modport master (
        output base_in, modulo_in, valid_in, ready_in,
        input  base_mont_out, one_mont_out, modulo_out, valid_out, busy_out, error_out
    );

    modport slave (
        input  base_in, modulo_in, valid_in, ready_in,
        output base_mont_out, one_mont_out, modulo_out, valid_out, busy_out, error_out
    );
endinterface

// File: rtl/mont_convert_mod_double_step.sv
// One shift-and-reduce step: acc' = 2*acc + bit, minus N when acc' >= N.
import mont_convert_pkg::*;

module mod_double_step #(
    parameter int unsigned WIDTH = RSA_WIDTH
) (
    input  logic [WIDTH:0]   acc,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] modulo,
    output logic [WIDTH:0]   acc_next
);
    logic [WIDTH+1:0] dbl;
    logic [WIDTH:0]   diff;

    // acc < N keeps dbl < 2N, so the wrapped WIDTH+1-bit difference is exact.
    always_comb begin
        dbl      = {acc, bit_in};
        diff     = dbl[WIDTH:0] - {1'b0, modulo};
        acc_next = (dbl >= {2'b00, modulo}) ? diff : dbl[WIDTH:0];
    end
endmodule

// File: rtl/mont_convert.sv
// Converts a base into Montgomery form (base*R mod N) and produces R mod N by serial doubling.
import mont_convert_pkg::*;

module mont_convert #(
    parameter int unsigned WIDTH = RSA_WIDTH
) (
    input logic          clk_in,
    input logic          rst_in,
    mont_convert_if.slave bus
);
    localparam int unsigned CW = cnt_width(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] base_q, base_d;
    logic [WIDTH-1:0] n_q, n_d;
    logic [WIDTH:0]   accb_q, accb_d, accb_nx;
    logic [WIDTH:0]   acco_q, acco_d, acco_nx;
    logic             pend_q, pend_d;
    logic [WIDTH-1:0] bm_q, bm_d;
    logic [WIDTH-1:0] om_q, om_d;
    logic [WIDTH-1:0] mo_q, mo_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             error_q, error_d;
    logic             bit_b, bit_o;

    // WIDTH is a power of two: the counter MSB marks the base half of the stream
    // and the low bits index the base directly.
    assign bit_b = cnt_q[CW-1] ? base_q[cnt_q[CW-2:0]] : 1'b0;
    assign bit_o = (cnt_q == CW'(WIDTH));

    mod_double_step #(.WIDTH(WIDTH)) u_step_base (
        .acc      (accb_q),
        .bit_in   (bit_b),
        .modulo   (n_q),
        .acc_next (accb_nx)
    );

    mod_double_step #(.WIDTH(WIDTH)) u_step_one (
        .acc      (acco_q),
        .bit_in   (bit_o),
        .modulo   (n_q),
        .acc_next (acco_nx)
    );

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            base_q  <= '0;
            n_q     <= '0;
            accb_q  <= '0;
            acco_q  <= '0;
            pend_q  <= 1'b0;
            bm_q    <= '0;
            om_q    <= '0;
            mo_q    <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
            n_q     <= n_d;
            accb_q  <= accb_d;
            acco_q  <= acco_d;
            pend_q  <= pend_d;
            bm_q    <= bm_d;
            om_q    <= om_d;
            mo_q    <= mo_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            error_q <= error_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        base_d  = base_q;
        n_d     = n_q;
        accb_d  = accb_q;
        acco_d  = acco_q;
        pend_d  = pend_q;
        bm_d    = bm_q;
        om_d    = om_q;
        mo_d    = mo_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        error_d = error_q;

        case (state_q)
            IDLE: begin
                // A degenerate modulus waits one cycle in IDLE, then reports without shifting.
                if (pend_q) begin
                    pend_d  = 1'b0;
                    bm_d    = '0;
                    om_d    = '0;
                    mo_d    = n_q;
                    valid_d = 1'b1;
                    error_d = 1'b1;
                    state_d = DONE;
                end else if (bus.valid_in) begin
                    base_d = bus.base_in;
                    n_d    = bus.modulo_in;
                    accb_d = '0;
                    acco_d = '0;
                    cnt_d  = CW'(2 * WIDTH - 1);
                    busy_d = 1'b1;
                    if (bus.modulo_in < WIDTH'(2)) begin
                        pend_d = 1'b1;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                accb_d = accb_nx;
                acco_d = acco_nx;
                if (cnt_q == '0) begin
                    bm_d    = accb_nx[WIDTH-1:0];
                    om_d    = acco_nx[WIDTH-1:0];
                    mo_d    = n_q;
                    valid_d = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE: begin
                if (bus.ready_in) begin
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    error_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.base_mont_out = bm_q;
    assign bus.one_mont_out  = om_q;
    assign bus.modulo_out    = mo_q;
    assign bus.valid_out     = valid_q;
    assign bus.busy_out      = busy_q;
    assign bus.error_out     = error_q;
endmodule
